// File: rtl/hazard_ctrl.sv
// Load-use stall and taken-branch flush control for the 5-stage MIPS pipeline.
// Optional perf counters (stall_count, flush_count) are built only when HAZARD_PERF_EN is defined.
module hazard_ctrl #(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned CNT_W             = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] ID_Rs,
  input  logic [4:0] ID_Rt,
  input  logic       ID_uses_rt,
  input  logic       EX_memread,
  input  logic [4:0] EX_Rt,
  input  logic       MEM_branch,
  input  logic       MEM_zero,
  output logic       PC_write,
  output logic       IF_ID_write,
  output logic       ID_EX_bubble,
  output logic       IF_ID_flush,
  output logic       ID_EX_flush,
  output logic       EX_MEM_flush
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
`endif
);

  localparam int unsigned CNT_BITS = 3;
  localparam logic [CNT_BITS-1:0] STALL_RELOAD = CNT_BITS'(LOAD_STALL_CYCLES - 1);

  if (LOAD_STALL_CYCLES < 1 || LOAD_STALL_CYCLES > 7 || CNT_W < 1) begin : g_bad_params
    $error("hazard_ctrl: LOAD_STALL_CYCLES must be 1..7 and CNT_W at least 1");
  end

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                hz;
  logic                tk;

  // Load in EX writes a register the ID instruction reads; $zero never counts.
  assign hz = EX_memread && (EX_Rt != 5'd0) &&
              ((EX_Rt == ID_Rs) || (ID_uses_rt && (EX_Rt == ID_Rt)));
  assign tk = MEM_branch && MEM_zero;

  // Next state and outputs; rst forces the free-running output values without waiting for a clock.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    PC_write     = 1'b1;
    IF_ID_write  = 1'b1;
    ID_EX_bubble = 1'b0;
    IF_ID_flush  = 1'b0;
    ID_EX_flush  = 1'b0;
    EX_MEM_flush = 1'b0;
    if (!rst) begin
      if (tk) begin
        IF_ID_flush  = 1'b1;
        ID_EX_flush  = 1'b1;
        EX_MEM_flush = 1'b1;
        state_d      = ST_RUN;
        cnt_d        = '0;
      end else if (state_q == ST_STALL) begin
        PC_write     = 1'b0;
        IF_ID_write  = 1'b0;
        ID_EX_bubble = 1'b1;
        cnt_d        = cnt_q - CNT_BITS'(1);
        if (cnt_q == CNT_BITS'(1)) begin
          state_d = ST_RUN;
        end
      end else if (hz) begin
        PC_write     = 1'b0;
        IF_ID_write  = 1'b0;
        ID_EX_bubble = 1'b1;
        if (LOAD_STALL_CYCLES > 1) begin
          state_d = ST_STALL;
          cnt_d   = STALL_RELOAD;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating event counters, cleared only by rst.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (ID_EX_bubble && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (tk && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: one instance with single-cycle stalls, one with three-cycle stalls.
// Perf counter checks are included when HAZARD_PERF_EN is defined.
module tb_hazard_ctrl;

  localparam logic [5:0] OUT_RUN   = 6'b110000;
  localparam logic [5:0] OUT_STALL = 6'b001000;
  localparam logic [5:0] OUT_FLUSH = 6'b110111;
  localparam int         CNT_MAX   = 3;

  typedef struct {
    string      tag;
    logic [5:0] e1;
    logic [5:0] e3;
    int         s1;
    int         f1;
    int         s3;
    int         f3;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] ID_Rs, ID_Rt, EX_Rt;
  logic       ID_uses_rt, EX_memread, MEM_branch, MEM_zero;

  logic a_pc, a_ifid_w, a_bub, a_ifid_f, a_idex_f, a_exmem_f;
  logic b_pc, b_ifid_w, b_bub, b_ifid_f, b_idex_f, b_exmem_f;
  logic [5:0] obs1, obs3;
`ifdef HAZARD_PERF_EN
  logic [1:0] a_sc, a_fc, b_sc, b_fc;
`endif

  int checks = 0;
  int errors = 0;
  exp_t sbq[$];

  int rem1 = 0, rem3 = 0;
  int sc1 = 0, fc1 = 0, sc3 = 0, fc3 = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(2)) u_l1 (
    .clk(clk), .rst(rst), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_uses_rt(ID_uses_rt),
    .EX_memread(EX_memread), .EX_Rt(EX_Rt), .MEM_branch(MEM_branch), .MEM_zero(MEM_zero),
    .PC_write(a_pc), .IF_ID_write(a_ifid_w), .ID_EX_bubble(a_bub),
    .IF_ID_flush(a_ifid_f), .ID_EX_flush(a_idex_f), .EX_MEM_flush(a_exmem_f)
`ifdef HAZARD_PERF_EN
    , .stall_count(a_sc), .flush_count(a_fc)
`endif
  );

  hazard_ctrl #(.LOAD_STALL_CYCLES(3), .CNT_W(2)) u_l3 (
    .clk(clk), .rst(rst), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_uses_rt(ID_uses_rt),
    .EX_memread(EX_memread), .EX_Rt(EX_Rt), .MEM_branch(MEM_branch), .MEM_zero(MEM_zero),
    .PC_write(b_pc), .IF_ID_write(b_ifid_w), .ID_EX_bubble(b_bub),
    .IF_ID_flush(b_ifid_f), .ID_EX_flush(b_idex_f), .EX_MEM_flush(b_exmem_f)
`ifdef HAZARD_PERF_EN
    , .stall_count(b_sc), .flush_count(b_fc)
`endif
  );

  assign obs1 = {a_pc, a_ifid_w, a_bub, a_ifid_f, a_idex_f, a_exmem_f};
  assign obs3 = {b_pc, b_ifid_w, b_bub, b_ifid_f, b_idex_f, b_exmem_f};

  task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Reference behaviour: remaining bubbles after the current one, plus saturating counts.
  task automatic model(input int lsc, input logic r, input logic hzv, input logic tkv,
                       inout int rem, inout int sc, inout int fc,
                       output logic [5:0] e, output int esc, output int efc);
    esc = r ? 0 : sc;
    efc = r ? 0 : fc;
    if (r) begin
      e = OUT_RUN; rem = 0;
    end else if (tkv) begin
      e = OUT_FLUSH; rem = 0;
    end else if (rem > 0) begin
      e = OUT_STALL; rem = rem - 1;
    end else if (hzv) begin
      e = OUT_STALL; rem = lsc - 1;
    end else begin
      e = OUT_RUN;
    end
    if (r) begin
      sc = 0; fc = 0;
    end else begin
      if (e[3] && sc < CNT_MAX) sc = sc + 1;
      if (tkv && fc < CNT_MAX) fc = fc + 1;
    end
  endtask

  // Drive one cycle of inputs after a falling edge, record expectations, compare before the next rise.
  task automatic step(input string tag, input logic r, input logic [4:0] rs, input logic [4:0] rt,
                      input logic ur, input logic mr, input logic [4:0] ert,
                      input logic br, input logic z);
    exp_t e;
    logic hzv, tkv;
    rst = r; ID_Rs = rs; ID_Rt = rt; ID_uses_rt = ur;
    EX_memread = mr; EX_Rt = ert; MEM_branch = br; MEM_zero = z;
    hzv = mr && (ert != 5'd0) && ((ert == rs) || (ur && (ert == rt)));
    tkv = br && z;
    e.tag = tag;
    model(1, r, hzv, tkv, rem1, sc1, fc1, e.e1, e.s1, e.f1);
    model(3, r, hzv, tkv, rem3, sc3, fc3, e.e3, e.s3, e.f3);
    sbq.push_back(e);
    #2;
    checks++;
    assert (sbq.size() > 0) else begin
      errors++;
      $error("FAIL %s: scoreboard empty, observed 0 entries expected 1", tag);
    end
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      check({e.tag, "/L1"}, obs1, e.e1);
      check({e.tag, "/L3"}, obs3, e.e3);
`ifdef HAZARD_PERF_EN
      check({e.tag, "/L1_stall_cnt"}, 6'(a_sc), 6'(e.s1));
      check({e.tag, "/L1_flush_cnt"}, 6'(a_fc), 6'(e.f1));
      check({e.tag, "/L3_stall_cnt"}, 6'(b_sc), 6'(e.s3));
      check({e.tag, "/L3_flush_cnt"}, 6'(b_fc), 6'(e.f3));
`endif
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; ID_Rs = '0; ID_Rt = '0; ID_uses_rt = 1'b0;
    EX_memread = 1'b0; EX_Rt = '0; MEM_branch = 1'b0; MEM_zero = 1'b0;
    @(negedge clk);
    //    tag              rst rs     rt     ur   mr   ert    br   z
    step("reset",          1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    step("idle",           0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    step("hz_rs",          0, 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
    step("hz_rs_c1",       0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    step("hz_rs_c2",       0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    step("hz_rs_done",     0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    step("zero_reg",       0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
    step("rt_unused",      0, 5'd3, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0);
    step("rt_used",        0, 5'd3, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0);
    step("rt_hold1",       0, 5'd3, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0);
    step("rt_hold2",       0, 5'd3, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0);
    step("rt_hold3",       0, 5'd3, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0);
    step("rt_release",     0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    step("taken_in_stall", 0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
    step("after_taken",    0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    step("not_taken",      0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    step("no_memread",     0, 5'd8, 5'd0, 1'b0, 1'b0, 5'd8, 1'b0, 1'b0);
    step("hz_pre_rst",     0, 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
    step("rst_mid_stall",  1, 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
    step("after_rst",      0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    step("hz_and_taken",   0, 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1);
    step("post_hz_taken",  0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    step("perf_rst",       1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step($sformatf("perf_hz%0d", i), 0, 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
    end
    step("perf_tk0",       0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
    step("perf_tk1",       0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
    step("perf_final",     0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
